// File: rtl/vga_scan_reader.sv
// Raster engine for 640x480@60 at the pixel clock: walks the screen, addresses the
// frame RAM for a centred image window and drives registered RGB/sync/blank to the DAC.
module vga_scan_reader #(
   parameter int         H_ACTIVE = 640,
   parameter int         H_FP     = 16,
   parameter int         H_SYNC   = 96,
   parameter int         H_BP     = 48,
   parameter int         V_ACTIVE = 480,
   parameter int         V_FP     = 10,
   parameter int         V_SYNC   = 2,
   parameter int         V_BP     = 33,
   parameter int         IMG_W    = 256,
   parameter int         IMG_H    = 256,
   parameter int         X0       = 192,
   parameter int         Y0       = 112,
   parameter int         RD_LAT   = 1,
   parameter logic [7:0] BORDER   = 8'h00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  vga_pixel_val,
   output logic [31:0] vga_pixel_addr,
   output logic [7:0]  vga_r,
   output logic [7:0]  vga_g,
   output logic [7:0]  vga_b,
   output logic        vga_hsync_n,
   output logic        vga_vsync_n,
   output logic        vga_blank_n,
   output logic        vga_sync_n,
   output logic        frame_start
);

   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW       = $clog2(H_TOTAL);
   localparam int VW       = $clog2(V_TOTAL);
   localparam int IMG_SIZE = IMG_W * IMG_H;
   localparam int RW       = $clog2(IMG_SIZE + 1);
   localparam int CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;

   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
   localparam logic [HW-1:0] HS_FIRST   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_LAST    = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [HW-1:0] WX_FIRST   = HW'(X0);
   localparam logic [HW-1:0] WX_LAST    = HW'(X0 + IMG_W - 1);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
   localparam logic [VW-1:0] VS_FIRST   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_LAST    = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [VW-1:0] WY_FIRST   = VW'(Y0);
   localparam logic [VW-1:0] WY_LAST    = VW'(Y0 + IMG_H - 1);
   localparam logic [RW-1:0] ROW_STEP   = RW'(IMG_W);

   generate
      if (X0 + IMG_W > H_ACTIVE) begin : g_chk_x
         $error("image window exceeds the horizontal active area");
      end
      if (Y0 + IMG_H > V_ACTIVE) begin : g_chk_y
         $error("image window exceeds the vertical active area");
      end
      if (RD_LAT < 1 || RD_LAT > 3) begin : g_chk_lat
         $error("frame RAM read latency must be 1..3");
      end
   endgenerate

   typedef struct packed {
      logic win;
      logic act;
      logic hs;
      logic vs;
      logic fs;
   } flag_t;

   logic [HW-1:0] hcnt_reg, hcnt_next;
   logic [VW-1:0] vcnt_reg, vcnt_next;
   logic [RW-1:0] row_base_reg, row_base_next;
   logic [CW-1:0] col_reg, col_next;
   logic [RW-1:0] addr_reg, addr_next;
   logic          frame_end;
   logic          win_x_cur, win_y_cur;
   logic          win_x_nxt, win_y_nxt;
   flag_t         cur_flags;
   flag_t         flag_pipe [RD_LAT];
   flag_t         tail_flags;
   logic [7:0]    pix_reg, pix_next;
   logic          hsync_n_reg, vsync_n_reg, blank_n_reg, fs_reg;

   // Raster counters: hcnt/vcnt always hold the position being addressed this cycle.
   always_comb begin
      hcnt_next = hcnt_reg + HW'(1);
      vcnt_next = vcnt_reg;
      frame_end = 1'b0;
      if (hcnt_reg == H_LAST) begin
         hcnt_next = '0;
         if (vcnt_reg == V_LAST) begin
            vcnt_next = '0;
            frame_end = 1'b1;
         end else begin
            vcnt_next = vcnt_reg + VW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hcnt_reg <= '0;
         vcnt_reg <= '0;
      end else begin
         hcnt_reg <= hcnt_next;
         vcnt_reg <= vcnt_next;
      end
   end

   assign win_x_cur = (hcnt_reg >= WX_FIRST) && (hcnt_reg <= WX_LAST);
   assign win_y_cur = (vcnt_reg >= WY_FIRST) && (vcnt_reg <= WY_LAST);
   assign win_x_nxt = (hcnt_next >= WX_FIRST) && (hcnt_next <= WX_LAST);
   assign win_y_nxt = (vcnt_next >= WY_FIRST) && (vcnt_next <= WY_LAST);

   // The address register is loaded from the next position so it lines up with hcnt/vcnt;
   // row base steps by one image line after the last window pixel, avoiding a multiplier.
   always_comb begin
      row_base_next = row_base_reg;
      if (frame_end) begin
         row_base_next = '0;
      end else if (hcnt_reg == WX_LAST && win_y_cur) begin
         row_base_next = row_base_reg + ROW_STEP;
      end
      col_next  = (win_x_nxt && hcnt_next != WX_FIRST) ? col_reg + CW'(1) : '0;
      addr_next = (win_x_nxt && win_y_nxt) ? row_base_next + RW'(col_next) : '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         row_base_reg <= '0;
         col_reg      <= '0;
         addr_reg     <= '0;
      end else begin
         row_base_reg <= row_base_next;
         col_reg      <= col_next;
         addr_reg     <= addr_next;
      end
   end

   assign vga_pixel_addr = 32'(addr_reg);

   always_comb begin
      cur_flags.win = win_x_cur && win_y_cur;
      cur_flags.act = (hcnt_reg <= H_ACT_LAST) && (vcnt_reg <= V_ACT_LAST);
      cur_flags.hs  = (hcnt_reg >= HS_FIRST) && (hcnt_reg <= HS_LAST);
      cur_flags.vs  = (vcnt_reg >= VS_FIRST) && (vcnt_reg <= VS_LAST);
      cur_flags.fs  = (hcnt_reg == '0) && (vcnt_reg == '0);
   end

   // Flags travel alongside the RAM read so they meet the returned pixel; sync flags are
   // stored active-high so a cleared pipeline means "no sync".
   generate
      for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_flag_pipe
         if (gi == 0) begin : g_first
            always_ff @(posedge clk or negedge reset) begin
               if (!reset) begin
                  flag_pipe[gi] <= '0;
               end else begin
                  flag_pipe[gi] <= cur_flags;
               end
            end
         end else begin : g_next
            always_ff @(posedge clk or negedge reset) begin
               if (!reset) begin
                  flag_pipe[gi] <= '0;
               end else begin
                  flag_pipe[gi] <= flag_pipe[gi-1];
               end
            end
         end
      end
   endgenerate

   assign tail_flags = flag_pipe[RD_LAT-1];

   always_comb begin
      pix_next = 8'h00;
      if (tail_flags.win) begin
         pix_next = vga_pixel_val;
      end else if (tail_flags.act) begin
         pix_next = BORDER;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pix_reg     <= 8'h00;
         hsync_n_reg <= 1'b1;
         vsync_n_reg <= 1'b1;
         blank_n_reg <= 1'b0;
         fs_reg      <= 1'b0;
      end else begin
         pix_reg     <= pix_next;
         hsync_n_reg <= ~tail_flags.hs;
         vsync_n_reg <= ~tail_flags.vs;
         blank_n_reg <= tail_flags.act;
         fs_reg      <= tail_flags.fs;
      end
   end

   assign vga_r       = pix_reg;
   assign vga_g       = pix_reg;
   assign vga_b       = pix_reg;
   assign vga_hsync_n = hsync_n_reg;
   assign vga_vsync_n = vsync_n_reg;
   assign vga_blank_n = blank_n_reg;
   assign frame_start = fs_reg;
   assign vga_sync_n  = 1'b0;

endmodule

// File: tb/tb_vga_scan_reader.sv
// Directed bench: a reduced raster (56x37, 16x16 window at (12,7)) at read latency 1 and 3,
// plus the default 640x480 build checked over its first line.
module tb_vga_scan_reader;

   localparam int HT = 56;
   localparam int VT = 37;
   localparam int FR = HT * VT;
   localparam logic [59:0] RST_VEC = {32'd0, 24'd0, 4'b1100};

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   logic [31:0] s1_addr, s3_addr, d_addr;
   logic [7:0]  s1_val, s3_val, d_val, s3_p1, s3_p2;
   logic [7:0]  s1_r, s1_g, s1_b, s3_r, s3_g, s3_b, d_r, d_g, d_b;
   logic        s1_hs, s1_vs, s1_bl, s1_sn, s1_fs;
   logic        s3_hs, s3_vs, s3_bl, s3_sn, s3_fs;
   logic        d_hs, d_vs, d_bl, d_sn, d_fs;
   logic [59:0] s1_vec, s3_vec, d_vec;

   vga_scan_reader #(
      .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
      .V_ACTIVE(30), .V_FP(2), .V_SYNC(2), .V_BP(3),
      .IMG_W(16), .IMG_H(16), .X0(12), .Y0(7), .RD_LAT(1), .BORDER(8'h5A)
   ) u_s1 (
      .clk(clk), .reset(reset), .vga_pixel_val(s1_val), .vga_pixel_addr(s1_addr),
      .vga_r(s1_r), .vga_g(s1_g), .vga_b(s1_b), .vga_hsync_n(s1_hs), .vga_vsync_n(s1_vs),
      .vga_blank_n(s1_bl), .vga_sync_n(s1_sn), .frame_start(s1_fs)
   );

   vga_scan_reader #(
      .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
      .V_ACTIVE(30), .V_FP(2), .V_SYNC(2), .V_BP(3),
      .IMG_W(16), .IMG_H(16), .X0(12), .Y0(7), .RD_LAT(3), .BORDER(8'h5A)
   ) u_s3 (
      .clk(clk), .reset(reset), .vga_pixel_val(s3_val), .vga_pixel_addr(s3_addr),
      .vga_r(s3_r), .vga_g(s3_g), .vga_b(s3_b), .vga_hsync_n(s3_hs), .vga_vsync_n(s3_vs),
      .vga_blank_n(s3_bl), .vga_sync_n(s3_sn), .frame_start(s3_fs)
   );

   vga_scan_reader u_def (
      .clk(clk), .reset(reset), .vga_pixel_val(d_val), .vga_pixel_addr(d_addr),
      .vga_r(d_r), .vga_g(d_g), .vga_b(d_b), .vga_hsync_n(d_hs), .vga_vsync_n(d_vs),
      .vga_blank_n(d_bl), .vga_sync_n(d_sn), .frame_start(d_fs)
   );

   // Frame RAM models returning the low address byte.
   always @(posedge clk) begin
      s1_val <= s1_addr[7:0];
      s3_p1  <= s3_addr[7:0];
      s3_p2  <= s3_p1;
      s3_val <= s3_p2;
      d_val  <= d_addr[7:0];
   end

   assign s1_vec = {s1_addr, s1_r, s1_g, s1_b, s1_hs, s1_vs, s1_bl, s1_fs};
   assign s3_vec = {s3_addr, s3_r, s3_g, s3_b, s3_hs, s3_vs, s3_bl, s3_fs};
   assign d_vec  = {d_addr, d_r, d_g, d_b, d_hs, d_vs, d_bl, d_fs};

   function automatic logic in_win(input int h, input int v);
      return (h >= 12) && (h < 28) && (v >= 7) && (v < 23);
   endfunction

   // Expected {addr, r, g, b, hsync_n, vsync_n, blank_n, frame_start} for the reduced raster
   // at cycle c after reset release, for read latency lat.
   function automatic logic [59:0] exp_scaled(input int c, input int lat);
      int p, h, v;
      logic [31:0] a;
      logic [7:0] pix;
      logic hs, vs, bl, fs;
      p = c % FR;
      h = p % HT;
      v = p / HT;
      a = in_win(h, v) ? 32'((v - 7) * 16 + (h - 12)) : 32'd0;
      if (c < lat + 1) begin
         pix = 8'h00; hs = 1'b1; vs = 1'b1; bl = 1'b0; fs = 1'b0;
      end else begin
         p = (c - lat - 1) % FR;
         h = p % HT;
         v = p / HT;
         bl = (h < 40) && (v < 30);
         if (in_win(h, v)) pix = 8'(((v - 7) * 16 + (h - 12)) % 256);
         else if (bl) pix = 8'h5A;
         else pix = 8'h00;
         hs = !((h >= 44) && (h <= 49));
         vs = !((v == 32) || (v == 33));
         fs = (p == 0);
      end
      return {a, pix, pix, pix, hs, vs, bl, fs};
   endfunction

   // Default build over line 0: no window pixels there, border is 0.
   function automatic logic [59:0] exp_def(input int c);
      int q;
      logic hs, bl, fs;
      if (c < 2) return RST_VEC;
      q  = c - 2;
      hs = !((q >= 656) && (q <= 751));
      bl = (q < 640);
      fs = (q == 0);
      return {32'd0, 24'd0, hs, 1'b1, bl, fs};
   endfunction

   task automatic check(input string tag, input int c, input logic [59:0] act,
                        input logic [59:0] exp);
      checks++;
      assert (act === exp) else begin
         failures++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, c, act, exp);
      end
   endtask

   // Called at the negedge right after reset release; cycle c is the state before edge c.
   task automatic run_scan(input int ncyc, input string phase);
      for (int c = 0; c < ncyc; c++) begin
         check({phase, "_lat1"}, c, s1_vec, exp_scaled(c, 1));
         check({phase, "_lat3"}, c, s3_vec, exp_scaled(c, 3));
         if (c <= 801) check({phase, "_default"}, c, d_vec, exp_def(c));
         @(negedge clk);
      end
   endtask

   initial begin
      reset = 1'b0;
      repeat (5) @(negedge clk);
      check("reset_lat1", -1, s1_vec, RST_VEC);
      check("reset_lat3", -1, s3_vec, RST_VEC);
      check("reset_default", -1, d_vec, RST_VEC);
      checks++;
      assert ({s1_sn, s3_sn, d_sn} === 3'b000) else begin
         failures++;
         $error("FAIL sync_n observed=%b expected=000", {s1_sn, s3_sn, d_sn});
      end

      reset = 1'b1;
      run_scan(2 * FR + 200, "frame");

      // Mid-frame reset: outputs must drop before any clock edge.
      reset = 1'b0;
      #1;
      check("async_lat1", -1, s1_vec, RST_VEC);
      check("async_lat3", -1, s3_vec, RST_VEC);
      check("async_default", -1, d_vec, RST_VEC);
      repeat (3) @(negedge clk);
      check("held_lat1", -1, s1_vec, RST_VEC);
      check("held_lat3", -1, s3_vec, RST_VEC);
      check("held_default", -1, d_vec, RST_VEC);

      reset = 1'b1;
      run_scan(FR + 60, "restart");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
